// File: rtl/mem_banked_responder.sv
// ============================================================================
// Module   : mem_banked_responder
// Brief    : Four-bank 16-bit memory responder with per-bank 3-cycle occupancy
//            and a two-stage read pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_banked_responder #(
    parameter int IDX_W = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_data_in,
    input  logic        mem_wr,
    input  logic        mem_rd,
    output logic [15:0] mem_DataOut,
    output logic        mem_stall,
    output logic [3:0]  mem_busy,
    output logic        mem_err
);

    localparam int c_DEPTH = 1 << IDX_W;

    logic [1:0]       w_bank;
    logic [IDX_W-1:0] w_idx;
    logic             w_in_range;
    logic             w_legal;
    logic             w_accept;
    logic             w_acc_rd;
    logic             w_acc_wr;
    logic [15:0]      w_rq [4];

    // Read pipeline: stage 1 holds the captured address, stage 2 the data.
    logic             r_v1;
    logic             r_v2;
    logic [1:0]       r_bank1;
    logic [IDX_W-1:0] r_idx1;
    logic [1:0]       r_bank2;

    assign w_bank = mem_addr[2:1];
    assign w_idx  = mem_addr[IDX_W+2:3];

    // With a full-width index every word address falls inside a bank.
    if (IDX_W >= 13) begin : g_range_full
        assign w_in_range = 1'b1;
    end else begin : g_range_chk
        assign w_in_range = (mem_addr[15:IDX_W+3] == '0);
    end

    assign w_legal   = (mem_rd ^ mem_wr) & ~mem_addr[0] & w_in_range;
    assign mem_err   = (mem_rd & mem_wr)
                     | ((mem_rd | mem_wr) & (mem_addr[0] | ~w_in_range));
    assign mem_stall = w_legal & mem_busy[w_bank];
    assign w_accept  = w_legal & ~mem_busy[w_bank];
    assign w_acc_rd  = w_accept & mem_rd;
    assign w_acc_wr  = w_accept & mem_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= w_acc_rd;
            r_v2 <= r_v1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc_rd) begin
            r_bank1 <= w_bank;
            r_idx1  <= w_idx;
        end
        if (r_v1) begin
            r_bank2 <= r_bank1;
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [15:0] r_mem [c_DEPTH];
        logic [15:0] r_q;
        logic [1:0]  r_cnt;
        logic        w_sel;

        assign w_sel = (w_bank == 2'(b));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= 2'd0;
            end else if (w_accept && w_sel) begin
                r_cnt <= 2'd3;
            end else if (r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end

        // Storage is deliberately left out of reset.
        always_ff @(posedge clk) begin
            if (w_acc_wr && w_sel) begin
                r_mem[w_idx] <= mem_data_in;
            end
            if (r_v1 && (r_bank1 == 2'(b))) begin
                r_q <= r_mem[r_idx1];
            end
        end

        assign mem_busy[b] = (r_cnt != 2'd0);
        assign w_rq[b]     = r_q;
    end

    assign mem_DataOut = r_v2 ? w_rq[r_bank2] : 16'h0000;

endmodule

`default_nettype wire

// File: tb/tb_mem_banked_responder.sv
// ============================================================================
// Module   : tb_mem_banked_responder
// Brief    : Directed and model-checked traffic for mem_banked_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_banked_responder;

    logic        clk;
    logic        rst;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic        mem_wr;
    logic        mem_rd;
    logic [15:0] mem_DataOut;
    logic        mem_stall;
    logic [3:0]  mem_busy;
    logic        mem_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state for the model-checked phase.
    logic [1:0]  m_cnt [4];
    logic [15:0] m_mem [16];
    logic [15:0] m_p0, m_p1, m_p2;

    mem_banked_responder #(.IDX_W(13)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_data_in (mem_data_in),
        .mem_wr      (mem_wr),
        .mem_rd      (mem_rd),
        .mem_DataOut (mem_DataOut),
        .mem_stall   (mem_stall),
        .mem_busy    (mem_busy),
        .mem_err     (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start a new cycle, drive the request, and return mid-cycle for sampling.
    task automatic cyc(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        mem_rd      = rd;
        mem_wr      = wr;
        mem_addr    = a;
        mem_data_in = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic mstep(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        logic [1:0] b;
        logic       req;
        logic       acc;
        logic [3:0] exp_busy;
        m_p0 = m_p1;
        m_p1 = m_p2;
        m_p2 = 16'h0000;
        cyc(rd, wr, a, d);
        b   = a[2:1];
        req = rd | wr;
        for (int k = 0; k < 4; k++) exp_busy[k] = (m_cnt[k] != 2'd0);
        check("rnd_busy",  16'(mem_busy),  16'(exp_busy));
        check("rnd_stall", 16'(mem_stall), 16'(req && (m_cnt[b] != 2'd0)));
        check("rnd_err",   16'(mem_err),   16'h0000);
        check("rnd_data",  mem_DataOut,    m_p0);
        acc = req && (m_cnt[b] == 2'd0);
        if (acc && rd) m_p2 = m_mem[a[4:1]];
        if (acc && wr) m_mem[a[4:1]] = d;
        for (int k = 0; k < 4; k++) begin
            if (acc && (b == 2'(k)))      m_cnt[k] = 2'd3;
            else if (m_cnt[k] != 2'd0)   m_cnt[k] = m_cnt[k] - 2'd1;
        end
    endtask

    initial begin
        rst         = 1'b1;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = 16'h0000;
        mem_data_in = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  16'(mem_busy),  16'h0000);
        check("rst_dout",  mem_DataOut,    16'h0000);
        check("rst_stall", 16'(mem_stall), 16'h0000);
        check("rst_err",   16'(mem_err),   16'h0000);
        rst = 1'b0;

        // Single write then read of the same word.
        cyc(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        check("w0_stall", 16'(mem_stall), 16'h0000);
        check("w0_err",   16'(mem_err),   16'h0000);
        for (int i = 1; i <= 3; i++) begin
            idle(1);
            check("w0_busy", 16'(mem_busy), 16'h0001);
        end
        cyc(1'b1, 1'b0, 16'h0010, 16'h5555);
        check("r4_busy",  16'(mem_busy),  16'h0000);
        check("r4_stall", 16'(mem_stall), 16'h0000);
        idle(1);
        check("r4_c5", mem_DataOut, 16'h0000);
        idle(1);
        check("r4_c6", mem_DataOut, 16'hBEEF);
        idle(1);
        check("r4_c7", mem_DataOut, 16'h0000);
        idle(3);

        // Back-to-back writes then reads across all four banks.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 16'(2 * i), 16'(i + 1));
            check("b2b_wstall", 16'(mem_stall), 16'h0000);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 16'(2 * i), 16'h0000);
            check("b2b_rstall", 16'(mem_stall), 16'h0000);
            if (i >= 2) check("b2b_data", mem_DataOut, 16'(i - 1));
        end
        idle(1);
        check("b2b_data", mem_DataOut, 16'h0003);
        idle(1);
        check("b2b_data", mem_DataOut, 16'h0004);
        idle(1);
        check("b2b_tail", mem_DataOut, 16'h0000);
        idle(3);

        // Same-bank conflict with a held retry.
        cyc(1'b0, 1'b1, 16'h0008, 16'h0808);
        idle(4);
        cyc(1'b1, 1'b0, 16'h0008, 16'h0000);
        check("cf_c0_stall", 16'(mem_stall), 16'h0000);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, 1'b0, 16'h0000, 16'h0000);
            check("cf_stall", 16'(mem_stall), 16'h0001);
            check("cf_err",   16'(mem_err),   16'h0000);
            if (i == 2) check("cf_c2_data", mem_DataOut, 16'h0808);
        end
        cyc(1'b1, 1'b0, 16'h0000, 16'h0000);
        check("cf_c4_stall", 16'(mem_stall), 16'h0000);
        idle(1);
        check("cf_c5_data", mem_DataOut, 16'h0000);
        idle(1);
        check("cf_c6_data", mem_DataOut, 16'h0001);
        idle(3);

        // Illegal requests.
        cyc(1'b1, 1'b1, 16'h0002, 16'hDEAD);
        check("il_rdwr_err",   16'(mem_err),   16'h0001);
        check("il_rdwr_stall", 16'(mem_stall), 16'h0000);
        cyc(1'b1, 1'b0, 16'h0003, 16'h0000);
        check("il_odd_err",  16'(mem_err),  16'h0001);
        check("il_odd_busy", 16'(mem_busy), 16'h0000);
        cyc(1'b0, 1'b1, 16'h0003, 16'hDEAD);
        check("il_oddw_err",  16'(mem_err),  16'h0001);
        check("il_oddw_busy", 16'(mem_busy), 16'h0000);
        idle(1);
        check("il_idle_busy",  16'(mem_busy),  16'h0000);
        check("il_idle_err",   16'(mem_err),   16'h0000);
        check("il_idle_stall", 16'(mem_stall), 16'h0000);
        cyc(1'b1, 1'b0, 16'h0002, 16'h0000);
        idle(1);
        idle(1);
        check("il_unchanged", mem_DataOut, 16'h0002);
        idle(3);

        // Reset one cycle after an accepted read, then accept right after release.
        cyc(1'b1, 1'b0, 16'h0004, 16'h0000);
        @(posedge clk);
        #1;
        check("ra_pre_busy", 16'(mem_busy), 16'h0004);
        mem_rd = 1'b0;
        rst    = 1'b1;
        #1;
        check("ra_busy", 16'(mem_busy), 16'h0000);
        check("ra_dout", mem_DataOut,   16'h0000);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        mem_wr      = 1'b1;
        mem_addr    = 16'h0006;
        mem_data_in = 16'h1234;
        @(negedge clk);
        check("ra_c2_dout",  mem_DataOut,    16'h0000);
        check("ra_c2_stall", 16'(mem_stall), 16'h0000);
        idle(1);
        check("ra_c3_busy", 16'(mem_busy), 16'h0008);
        check("ra_c3_dout", mem_DataOut,   16'h0000);
        idle(4);

        // Reset while read data is on the output.
        cyc(1'b1, 1'b0, 16'h0006, 16'h0000);
        idle(2);
        check("rb_dout_pre", mem_DataOut,   16'h1234);
        check("rb_busy_pre", 16'(mem_busy), 16'h0008);
        rst = 1'b1;
        #1;
        check("rb_dout", mem_DataOut,   16'h0000);
        check("rb_busy", 16'(mem_busy), 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Model-checked traffic over a 16-word window.
        for (int k = 0; k < 4; k++) m_cnt[k] = 2'd0;
        m_p0 = 16'h0000;
        m_p1 = 16'h0000;
        m_p2 = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            mstep(1'b0, 1'b1, {11'b0, 2'(i / 4), 2'(i % 4), 1'b0}, 16'(16'hA000 + i));
        end
        for (int i = 0; i < 400; i++) begin
            int op;
            logic [15:0] a;
            op = int'($urandom_range(0, 2));
            a  = {11'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0};
            mstep(op == 1, op == 2, a, 16'($urandom_range(0, 65535)));
        end
        for (int i = 0; i < 4; i++) mstep(1'b0, 1'b0, 16'h0000, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_banked_responder.md
MEM_BANKED_RESPONDER -- requirements
Module: mem_banked_responder

Interface
REQ-001 SHALL have parameter IDX_W, default 13: word-index width per bank, giving 2^IDX_W 16-bit words per bank.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port mem_addr, input, 16: byte address; bank = mem_addr[2:1], index = mem_addr[15:3].
REQ-005 SHALL have port mem_data_in, input, 16: write data.
REQ-006 SHALL have port mem_wr, input, 1: write request.
REQ-007 SHALL have port mem_rd, input, 1: read request.
REQ-008 SHALL have port mem_DataOut, output, 16: read data.
REQ-009 SHALL have port mem_stall, output, 1: current request rejected because its target bank is busy.
REQ-010 SHALL have port mem_busy, output, 4: per-bank busy flags.
REQ-011 SHALL have port mem_err, output, 1: illegal request in the current cycle.

Function
REQ-012 SHALL hold four independent banks of 2^IDX_W x 16 storage.
REQ-013 SHALL treat a request as legal only when all of these hold: (mem_rd XOR mem_wr) = 1, mem_addr[0] = 0, and mem_addr[15:3] < 2^IDX_W.
REQ-014 SHALL, when mem_rd = 1 and mem_wr = 1, or mem_rd|mem_wr = 1 with mem_addr[0] = 1, drive mem_err = 1 combinationally in that cycle; the request is ignored with no state change.
REQ-015 SHALL drive mem_stall = 1 combinationally when a legal request targets a bank whose mem_busy bit is 1; the request is ignored and the requester must hold and retry.
REQ-016 SHALL accept a legal request when its target bank is not busy; acceptance occurs at the clock edge ending request cycle t.
REQ-017 SHALL keep a 2-bit occupancy counter per bank; accept loads it with 3; it decrements each cycle while nonzero; mem_busy[b] = (counter != 0).
REQ-018 SHALL therefore block the bank for cycles t+1, t+2 and t+3; a new request to that bank is accepted no earlier than cycle t+4.
REQ-019 SHALL write mem_data_in into bank[index] at the edge ending cycle t for an accepted write.
REQ-020 SHALL, for a read accepted in cycle t, drive that word on mem_DataOut during cycle t+2 only (two-stage pipeline: address capture, then data register).
REQ-021 SHALL drive mem_DataOut = 16'h0000 in every cycle with no returning read data.
REQ-022 SHALL let requests to different banks be accepted in consecutive cycles; back-to-back reads to banks 0,1,2,3 in cycles t..t+3 SHALL return data in cycles t+2..t+5 in order.
REQ-023 SHALL return the pre-write value for a read whose read cycle precedes the write in time; same-bank hazards cannot occur because of REQ-018.
REQ-024 SHALL ignore mem_data_in when mem_wr = 0 and hold storage unchanged on rejected or illegal requests.
REQ-025 SHALL hold mem_stall = 0 and mem_err = 0 when no request is present.

Reset
REQ-026 SHALL, while rst = 1, immediately force the following regardless of clk: all counters = 0, mem_busy = 4'b0000, pipeline valid bits = 0, mem_DataOut = 0.
REQ-027 SHALL cancel in-flight reads when rst is asserted mid-operation; no data is returned after reset release.
REQ-028 SHALL not reset storage contents; the bench SHALL not rely on their post-reset values.
REQ-029 SHALL accept a request in the first cycle after rst deasserts.

Verification
REQ-030 Write 16'hBEEF to 0x0010 in cycle 0; read 0x0010 in cycle 4 -> mem_stall = 0; mem_DataOut = 16'hBEEF in cycle 6; 0 in cycles 5 and 7.
REQ-031 Write 0x0000, 0x0002, 0x0004, 0x0006 in cycles 0-3 with data 1-4; read the same addresses in cycles 4-7 -> data 1,2,3,4 in cycles 6-9; no stalls.
REQ-032 Read 0x0008 in cycle 0; read 0x0000 in cycle 1 (same bank) -> mem_stall = 1 in cycles 1-3; the held retry is accepted in cycle 4; data in cycle 6.
REQ-033 mem_rd = mem_wr = 1 at 0x0002; then read at 0x0003 -> mem_err = 1 in both cycles; mem_busy stays 0; storage is unchanged.
REQ-034 Accept a read in cycle 0; assert rst in cycle 1 -> mem_busy = 0 and mem_DataOut = 0 immediately; no data appears in cycle 2.
REQ-035 Random legal traffic against a reference memory model -> every accepted read matches the model; stall occurs only while mem_busy is set for the target bank.
